alu_bist: RTL and testbench
===========================

ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter VECTORS_PER_OP, default 16, meaning vectors issued per ALU opcode (range 1..256).
REQ-002 Parameter SEED, default 32'hACE1_2025, meaning non-zero LFSR start value reloaded on each start.
REQ-003 clk  input  1  clock; single clock domain; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to run the full self-test; honoured only in IDLE or DONE.
REQ-006 alu_a  output  32  operand A driven into the ALU under test.
REQ-007 alu_b  output  32  operand B driven into the ALU under test.
REQ-008 alu_control  output  4  opcode driven into the ALU under test.
REQ-009 alu_result  input  32  ALU result, combinational response to alu_a/alu_b/alu_control.
REQ-010 alu_zero  input  1  ALU zero flag.
REQ-011 busy  output  1  high in DRIVE and CHECK.
REQ-012 done  output  1  high in DONE, held until next start or reset.
REQ-013 pass  output  1  valid when done; 1 iff err_count==0.
REQ-014 err_count  output  8  mismatching vectors, saturating at 255.
REQ-015 first_err_op / first_err_idx  output  4 / 8  opcode and vector index of first mismatch; 0 if none.

Function
REQ-016 Opcode map: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU; shifts use b[4:0]; SLT/SLTU results are 32'h0 or 32'h1.
REQ-017 FSM states IDLE, DRIVE, CHECK, DONE; IDLE->DRIVE and DONE->DRIVE on start; DRIVE->CHECK always; CHECK->DRIVE if vectors remain, else CHECK->DONE.
REQ-018 On start: LFSR=SEED, opcode=0000, index=0, err_count=0, first_err_*=0.
REQ-019 DRIVE registers alu_a/alu_b/alu_control; index 0 of each opcode uses a=b=0; other indices use two successive LFSR words (a first, then b).
REQ-020 CHECK compares alu_result against internal golden result and alu_zero against (golden==0); any difference is one mismatch.
REQ-021 Opcodes run in ascending order 0000..1001; index advances 0..VECTORS_PER_OP-1 per opcode.
REQ-022 Each vector costs exactly 2 cycles; done rises 20*VECTORS_PER_OP cycles after the start cycle.
REQ-023 first_err_op/idx capture only on the first mismatch of a run.
REQ-024 err_count increments per mismatch and holds at 255.
REQ-025 start while busy is ignored; start in DONE clears done on the next cycle and reruns.
REQ-026 LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, advances once per word consumed; never loaded with zero.
REQ-027 alu_a/alu_b/alu_control hold their last value in IDLE and DONE.

Reset
REQ-028 rst forces IDLE at the next edge, including mid-run; partial results discarded.
REQ-029 Reset values: alu_a=0, alu_b=0, alu_control=0000, busy=0, done=0, pass=0, err_count=0, first_err_op=0, first_err_idx=0, LFSR=SEED.

Structure
REQ-030 Shared package holds opcode constants (ALU_ADD..ALU_SLTU), the 4-bit opcode typedef, NUM_ALU_OPS=10, and the golden-result function used here and by the processor's ALU.
REQ-031 One sub-module, lfsr32 (load, advance, 32-bit value); FSM, counters and comparator stay in alu_bist.

Verification
REQ-032 Correct ALU attached, VECTORS_PER_OP=16, start pulse -> done at cycle 320, pass=1, err_count=0, first_err_op=0.
REQ-033 ALU with result[0] inverted for SLL only -> err_count=16, first_err_op=0101, first_err_idx=0, pass=0.
REQ-034 ALU with alu_zero stuck at 0 -> first_err_op=0000, first_err_idx=0, err_count>=10.
REQ-035 VECTORS_PER_OP=32, ALU result forced to 32'hFFFF_FFFF -> err_count=255 (saturated), pass=0.
REQ-036 rst asserted at cycle 50 of a run, released, start again -> identical alu_a/alu_b sequence from SEED; final results match a reset-free run.
REQ-037 start pulsed at cycles 5 and 40 of a run -> both ignored, done still at cycle 320 after the original start.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared ALU definitions: opcode map, golden result function, BIST state encoding.
// The processor's ALU and the self-test engine both import this package.
package alu_bist_pkg;

  localparam int DATA_W      = 32;
  localparam int NUM_ALU_OPS = 10;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b0001;
  localparam alu_op_t ALU_AND  = 4'b0010;
  localparam alu_op_t ALU_OR   = 4'b0011;
  localparam alu_op_t ALU_XOR  = 4'b0100;
  localparam alu_op_t ALU_SLL  = 4'b0101;
  localparam alu_op_t ALU_SRL  = 4'b0110;
  localparam alu_op_t ALU_SRA  = 4'b0111;
  localparam alu_op_t ALU_SLT  = 4'b1000;
  localparam alu_op_t ALU_SLTU = 4'b1001;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [DATA_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } bist_state_t;

  function automatic logic [DATA_W-1:0] alu_golden(
    input alu_op_t           op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [DATA_W-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = sa >>> b[4:0];
      ALU_SLT:  r = {{(DATA_W-1){1'b0}}, (sa < sb)};
      ALU_SLTU: r = {{(DATA_W-1){1'b0}}, (a < b)};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// Operand/opcode/result bus between the self-test engine and the ALU under test.
interface alu_bist_if;
  import alu_bist_pkg::*;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  alu_op_t           alu_control;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  modport master (
    output alu_a,
    output alu_b,
    output alu_control,
    input  alu_result,
    input  alu_zero
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_control,
    output alu_result,
    output alu_zero
  );
endinterface

// File: rtl/alu_bist_lfsr32.sv
// 32-bit Galois LFSR operand source; load restores SEED, advance steps one word.
module lfsr32
  import alu_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = 32'hACE1_2025
) (
  input  logic              clk,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] value_nxt
);

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // A non-zero SEED can never step to zero, so the lock-up state is unreachable
  assign value_nxt = lfsr_step(value);

  always_ff @(posedge clk) begin
    if (load)
      value <= SEED;
    else if (advance)
      value <= value_nxt;
  end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test: sweeps every opcode with LFSR operands, compares the
// ALU's result and zero flag against the golden model, and reports errors.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int                VECTORS_PER_OP = 16,
  parameter logic [DATA_W-1:0] SEED           = 32'hACE1_2025
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  alu_bist_if.master        alu,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [3:0]        first_err_op,
  output logic [7:0]        first_err_idx
);

  localparam logic [7:0] LAST_IDX = 8'(VECTORS_PER_OP - 1);

  bist_state_t       state;
  alu_op_t           op_idx;
  logic [7:0]        vec_idx;
  logic [DATA_W-1:0] lfsr_value;
  logic [DATA_W-1:0] lfsr_value_nxt;
  logic [DATA_W-1:0] golden;
  logic              start_ok;
  logic              lfsr_load;
  logic              lfsr_adv;
  logic              mismatch;
  logic              last_vec;
  logic [7:0]        err_nxt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign lfsr_load = rst || start_ok;
  // Index 0 uses a=b=0; otherwise DRIVE consumes a, CHECK steps past b
  assign lfsr_adv  = ((state == ST_DRIVE) || (state == ST_CHECK)) && (vec_idx != 8'd0);

  lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk       (clk),
    .load      (lfsr_load),
    .advance   (lfsr_adv),
    .value     (lfsr_value),
    .value_nxt (lfsr_value_nxt)
  );

  assign golden   = alu_golden(alu.alu_control, alu.alu_a, alu.alu_b);
  assign mismatch = (alu.alu_result != golden) || (alu.alu_zero != (golden == '0));
  assign last_vec = (vec_idx == LAST_IDX) && (op_idx == ALU_SLTU);
  assign err_nxt  = mismatch ? sat_inc(err_count) : err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      op_idx          <= ALU_ADD;
      vec_idx         <= 8'd0;
      alu.alu_a       <= '0;
      alu.alu_b       <= '0;
      alu.alu_control <= ALU_ADD;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= 8'd0;
      first_err_op    <= 4'd0;
      first_err_idx   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_DRIVE;
            op_idx        <= ALU_ADD;
            vec_idx       <= 8'd0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= 8'd0;
            first_err_op  <= 4'd0;
            first_err_idx <= 8'd0;
          end
        end
        ST_DRIVE: begin
          if (vec_idx == 8'd0) begin
            alu.alu_a <= '0;
            alu.alu_b <= '0;
          end else begin
            alu.alu_a <= lfsr_value;
            alu.alu_b <= lfsr_value_nxt;
          end
          alu.alu_control <= op_idx;
          state           <= ST_CHECK;
        end
        ST_CHECK: begin
          err_count <= err_nxt;
          // err_count is still zero only until the first mismatch of the run
          if (mismatch && (err_count == 8'd0)) begin
            first_err_op  <= op_idx;
            first_err_idx <= vec_idx;
          end
          if (last_vec) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 8'd0);
          end else begin
            state <= ST_DRIVE;
            if (vec_idx == LAST_IDX) begin
              vec_idx <= 8'd0;
              op_idx  <= op_idx + 4'd1;
            end else begin
              vec_idx <= vec_idx + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a behavioural ALU with injectable faults plus a reference
// model that predicts the operand sequence and the error report of each run.
module tb_alu_bist;
  import alu_bist_pkg::*;

  localparam logic [31:0] TB_SEED = 32'hACE1_2025;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start16, start32;
  logic       busy16, done16, pass16;
  logic       busy32, done32, pass32;
  logic [7:0] err16, fidx16, err32, fidx32;
  logic [3:0] fop16, fop32;
  int         fault16 = 0;
  int         fault32 = 3;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [3:0]  exp_op[$];
  int          exp_err, exp_fop, exp_fidx;

  alu_bist_if bus16();
  alu_bist_if bus32();

  alu_bist #(.VECTORS_PER_OP(16), .SEED(TB_SEED)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .alu(bus16),
    .busy(busy16), .done(done16), .pass(pass16), .err_count(err16),
    .first_err_op(fop16), .first_err_idx(fidx16)
  );

  alu_bist #(.VECTORS_PER_OP(32), .SEED(TB_SEED)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .alu(bus32),
    .busy(busy32), .done(done32), .pass(pass32), .err_count(err32),
    .first_err_op(fop32), .first_err_idx(fidx32)
  );

  // Reference ALU written from the opcode table
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0: return a + b;
      4'd1: return a + (~b) + 32'd1;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd8: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd9: return {31'd0, (a < b)};
      default: return 32'h0;
    endcase
  endfunction

  // Fault modes: 0 good, 1 SLL result bit0 inverted, 2 zero stuck at 0, 3 result all ones
  function automatic logic [31:0] faulty_res(input int fault, input logic [3:0] op,
                                             input logic [31:0] good);
    if (fault == 1 && op == 4'd5) return good ^ 32'h1;
    if (fault == 3) return 32'hFFFF_FFFF;
    return good;
  endfunction

  function automatic logic faulty_zero(input int fault, input logic [31:0] res);
    return (fault == 2) ? 1'b0 : (res == 32'h0);
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  always_comb begin
    logic [31:0] r16, r32;
    r16 = faulty_res(fault16, bus16.alu_control, ref_alu(bus16.alu_control, bus16.alu_a, bus16.alu_b));
    r32 = faulty_res(fault32, bus32.alu_control, ref_alu(bus32.alu_control, bus32.alu_a, bus32.alu_b));
    bus16.alu_result = r16;
    bus16.alu_zero   = faulty_zero(fault16, r16);
    bus32.alu_result = r32;
    bus32.alu_zero   = faulty_zero(fault32, r32);
  end

  // Predict the whole run: vector list plus the error report a faulty ALU produces
  task automatic build_expected(input int v, input int fault);
    logic [31:0] s, a, b, good, obs;
    int cnt;
    s = TB_SEED;
    cnt = 0;
    exp_fop = 0;
    exp_fidx = 0;
    exp_a.delete();
    exp_b.delete();
    exp_op.delete();
    for (int op = 0; op < 10; op++) begin
      for (int idx = 0; idx < v; idx++) begin
        if (idx == 0) begin
          a = 32'h0;
          b = 32'h0;
        end else begin
          a = s;
          s = lfsr_next(s);
          b = s;
          s = lfsr_next(s);
        end
        exp_a.push_back(a);
        exp_b.push_back(b);
        exp_op.push_back(4'(op));
        good = ref_alu(4'(op), a, b);
        obs  = faulty_res(fault, 4'(op), good);
        if (obs != good || faulty_zero(fault, obs) != (good == 32'h0)) begin
          if (cnt == 0) begin
            exp_fop = op;
            exp_fidx = idx;
          end
          cnt++;
        end
      end
    end
    exp_err = (cnt > 255) ? 255 : cnt;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic pulse_start16();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
  endtask

  // Full run on the 16-vector instance; glitch pulses start at cycles 5 and 40
  task automatic run16(input int fault, input bit glitch);
    int n;
    int k;
    n = 20 * 16;
    fault16 = fault;
    build_expected(16, fault);
    pulse_start16();
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      if (glitch) start16 = (c == 4 || c == 39);
      if (c == 1) begin
        chk("busy_at_1", 32'(busy16), 32'd1);
        chk("done_cleared", 32'(done16), 32'd0);
      end
      if (c % 2 == 1) begin
        k = (c - 1) / 2;
        chk("vec_a", bus16.alu_a, exp_a[k]);
        chk("vec_b", bus16.alu_b, exp_b[k]);
        chk("vec_op", 32'(bus16.alu_control), 32'(exp_op[k]));
      end
      if (c == n - 1) chk("done_early", 32'(done16), 32'd0);
    end
    chk("done_at_320", 32'(done16), 32'd1);
    chk("busy_end", 32'(busy16), 32'd0);
    chk("err_count", 32'(err16), 32'(exp_err));
    chk("pass", 32'(pass16), 32'(exp_err == 0));
    chk("first_op", 32'(fop16), 32'(exp_fop));
    chk("first_idx", 32'(fidx16), 32'(exp_fidx));
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", 32'(done16), 32'd1);
    chk("a_hold", bus16.alu_a, exp_a[exp_a.size() - 1]);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    start16 = 1'b0;
    start32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    chk("rst_pass", 32'(pass16), 32'd0);
    chk("rst_err", 32'(err16), 32'd0);
    chk("rst_a", bus16.alu_a, 32'd0);
    chk("rst_b", bus16.alu_b, 32'd0);
    chk("rst_ctrl", 32'(bus16.alu_control), 32'd0);
    chk("rst_fop", 32'(fop16), 32'd0);
    chk("rst_fidx", 32'(fidx16), 32'd0);
    rst = 1'b0;

    run16(0, 1'b0);
    chk("good_pass", 32'(pass16), 32'd1);

    run16(1, 1'b0);
    chk("sll_err16", 32'(err16), 32'd16);
    chk("sll_fop", 32'(fop16), 32'd5);

    run16(2, 1'b0);
    chk("zero_fop", 32'(fop16), 32'd0);
    chk("zero_min10", 32'(err16 >= 8'd10), 32'd1);

    // Reset in the middle of a faulty run, then rerun cleanly from SEED
    fault16 = 1;
    pulse_start16();
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy16), 32'd0);
    chk("midrst_done", 32'(done16), 32'd0);
    chk("midrst_err", 32'(err16), 32'd0);
    chk("midrst_a", bus16.alu_a, 32'd0);
    run16(0, 1'b0);

    run16(0, 1'b1);

    for (int i = 0; i < 2; i++) run16(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Saturation on the 32-vector instance driven by an all-ones ALU
    build_expected(32, 3);
    @(negedge clk);
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    c = 0;
    while (c < 700 && !done32) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("sat_latency", 32'(c), 32'd640);
    chk("sat_err", 32'(err32), 32'd255);
    chk("sat_model", 32'(err32), 32'(exp_err));
    chk("sat_pass", 32'(pass32), 32'd0);
    chk("sat_fop", 32'(fop32), 32'(exp_fop));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
